// File: rtl/srcout_select_pipe.sv
// Source-operand select stage: returns the requested channel's value, waiting
// (bounded by MAX_WAIT) while that channel is still busy.
module srcout_select_pipe #(
  parameter int WIDTH    = 32,
  parameter int NSRC     = 6,
  parameter int SELW     = 3,
  parameter int MAX_WAIT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [NSRC-1:0]       src_busy,
  input  logic [SELW-1:0]       sel,
  input  logic                  in_valid,
  input  logic                  flush,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  err_sel,
  output logic                  err_timeout,
  output logic                  dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready;
  // in_ready is high exactly in IDLE, and in_valid outside IDLE is ignored.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e           state_q;
  logic [SELW-1:0]  sel_q;
  logic [7:0]       cnt_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             err_sel_q;
  logic             err_timeout_q;

  logic [31:0]      sel_ext;
  logic             sel_oob;
  logic [WIDTH-1:0] req_data;
  logic             req_busy;
  logic [WIDTH-1:0] wait_data;
  logic             wait_busy;

  function automatic logic [WIDTH-1:0] pick_data(input logic [SELW-1:0] s,
                                                 input logic [NSRC*WIDTH-1:0] d);
    pick_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (s == SELW'(k)) pick_data = d[k*WIDTH +: WIDTH];
    end
  endfunction

  function automatic logic pick_busy(input logic [SELW-1:0] s,
                                     input logic [NSRC-1:0] b);
    pick_busy = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (s == SELW'(k)) pick_busy = b[k];
    end
  endfunction

  always_comb begin
    sel_ext   = 32'(sel);
    sel_oob   = (sel_ext >= 32'(NSRC));
    req_data  = pick_data(sel, in_data);
    req_busy  = pick_busy(sel, src_busy);
    wait_data = pick_data(sel_q, in_data);
    wait_busy = pick_busy(sel_q, src_busy);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      err_sel_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      err_sel_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_valid) begin
              if (sel_oob) begin
                out_data_q  <= '0;
                out_valid_q <= 1'b1;
                err_sel_q   <= 1'b1;
              end else if (!req_busy) begin
                out_data_q  <= req_data;
                out_valid_q <= 1'b1;
              end else begin
                sel_q   <= sel;
                cnt_q   <= '0;
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            // A busy drop on the limit edge still counts as a capture.
            if (!wait_busy) begin
              out_data_q  <= wait_data;
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= S_IDLE;
            end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
              out_data_q    <= '0;
              out_valid_q   <= 1'b1;
              err_timeout_q <= 1'b1;
              cnt_q         <= '0;
              state_q       <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_sel     = err_sel_q;
  assign err_timeout = err_timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_srcout_select_pipe.sv
// Directed bench for srcout_select_pipe: one default-limit instance and one
// with MAX_WAIT=4 sharing the same stimulus.
module tb_srcout_select_pipe;

  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SELW  = 3;

  logic                  clk;
  logic                  reset;
  logic [NSRC*WIDTH-1:0] in_data;
  logic [NSRC-1:0]       src_busy;
  logic [SELW-1:0]       sel;
  logic                  in_valid;
  logic                  flush;

  logic             a_ready, a_valid, a_esel, a_eto, a_state;
  logic [WIDTH-1:0] a_data;
  logic             b_ready, b_valid, b_esel, b_eto, b_state;
  logic [WIDTH-1:0] b_data;

  int n_cmp = 0;
  int n_err = 0;

  srcout_select_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MAX_WAIT(64)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .src_busy(src_busy), .sel(sel),
    .in_valid(in_valid), .flush(flush), .in_ready(a_ready), .out_data(a_data),
    .out_valid(a_valid), .err_sel(a_esel), .err_timeout(a_eto), .dbg_state_o(a_state)
  );

  srcout_select_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .MAX_WAIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_data(in_data), .src_busy(src_busy), .sel(sel),
    .in_valid(in_valid), .flush(flush), .in_ready(b_ready), .out_data(b_data),
    .out_valid(b_valid), .err_sel(b_esel), .err_timeout(b_eto), .dbg_state_o(b_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
    in_data[k*WIDTH +: WIDTH] = v;
  endtask

  task automatic req(input logic [SELW-1:0] s);
    sel      = s;
    in_valid = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    in_data  = '0;
    src_busy = '0;
    sel      = '0;
    in_valid = 1'b0;
    flush    = 1'b0;
    set_ch(0, 32'h0000_DEAD);
    set_ch(1, 32'h1111_1111);
    set_ch(2, 32'h2222_2222);
    set_ch(3, 32'h0000_00AA);
    set_ch(4, 32'h4444_4444);
    set_ch(5, 32'h5555_5555);
    #1;
    chk("rst_data",  a_data,  32'h0);
    chk("rst_valid", a_valid, 32'h0);
    chk("rst_esel",  a_esel,  32'h0);
    chk("rst_eto",   a_eto,   32'h0);
    chk("rst_ready", a_ready, 32'h1);
    chk("rst_state", a_state, 32'h0);
    chk("rst_b_data", b_data, 32'h0);
    step();
    step();

    // plain hit on ch3, first edge after release
    reset = 1'b1;
    req(3);
    step();
    chk("hit_data",  a_data,  32'h0000_00AA);
    chk("hit_valid", a_valid, 32'h1);
    chk("hit_esel",  a_esel,  32'h0);
    chk("hit_ready", a_ready, 32'h1);
    in_valid = 1'b0;
    step();
    chk("hit_pulse", a_valid, 32'h0);
    chk("hit_hold",  a_data,  32'h0000_00AA);

    // out-of-range select
    req(7);
    step();
    chk("oob_data",  a_data,  32'h0);
    chk("oob_valid", a_valid, 32'h1);
    chk("oob_esel",  a_esel,  32'h1);
    chk("oob_ready", a_ready, 32'h1);
    in_valid = 1'b0;
    step();
    chk("oob_esel_pulse", a_esel, 32'h0);
    chk("oob_valid_pulse", a_valid, 32'h0);

    // busy ch0 for five edges, second request ignored during the wait
    src_busy[0] = 1'b1;
    req(0);
    step();
    chk("w_accept_valid", a_valid, 32'h0);
    chk("w_accept_ready", a_ready, 32'h0);
    chk("w_accept_state", a_state, 32'h1);
    in_valid = 1'b0;
    step();
    chk("w_e1_ready", a_ready, 32'h0);
    req(2);
    step();
    chk("w_e2_valid", a_valid, 32'h0);
    chk("w_e2_ready", a_ready, 32'h0);
    chk("w_e2_data",  a_data,  32'h0);
    in_valid = 1'b0;
    step();
    step();
    chk("w_e4_valid", a_valid, 32'h0);
    set_ch(0, 32'h0000_1234);
    src_busy[0] = 1'b0;
    step();
    chk("w_cap_data",  a_data,  32'h0000_1234);
    chk("w_cap_valid", a_valid, 32'h1);
    chk("w_cap_eto",   a_eto,   32'h0);
    chk("w_cap_ready", a_ready, 32'h1);
    step();
    chk("w_cap_pulse", a_valid, 32'h0);
    chk("w_cap_hold",  a_data,  32'h0000_1234);

    // timeout at MAX_WAIT=4 on ch1
    src_busy[1] = 1'b1;
    req(1);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("to_e3_valid", b_valid, 32'h0);
    chk("to_e3_ready", b_ready, 32'h0);
    step();
    chk("to_e4_valid", b_valid, 32'h1);
    chk("to_e4_eto",   b_eto,   32'h1);
    chk("to_e4_data",  b_data,  32'h0);
    chk("to_e4_ready", b_ready, 32'h1);
    chk("to_long_wait", a_ready, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("to_eto_pulse", b_eto, 32'h0);
    chk("fl_long_ready", a_ready, 32'h1);
    chk("fl_long_valid", a_valid, 32'h0);
    chk("fl_long_data",  a_data,  32'h0000_1234);

    // busy drop on the limit edge is a capture
    req(1);
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    src_busy[1] = 1'b0;
    step();
    chk("lim_cap_valid", b_valid, 32'h1);
    chk("lim_cap_eto",   b_eto,   32'h0);
    chk("lim_cap_data",  b_data,  32'h1111_1111);
    chk("lim_cap_a",     a_data,  32'h1111_1111);
    step();

    // flush beats a same-edge capture and a same-edge request
    src_busy[2] = 1'b1;
    req(2);
    step();
    in_valid = 1'b0;
    step();
    src_busy[2] = 1'b0;
    flush = 1'b1;
    req(3);
    step();
    chk("fl_valid", a_valid, 32'h0);
    chk("fl_ready", a_ready, 32'h1);
    chk("fl_data",  a_data,  32'h1111_1111);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_discard", a_valid, 32'h0);

    // asynchronous reset mid-wait
    src_busy[5] = 1'b1;
    req(5);
    step();
    in_valid = 1'b0;
    step();
    chk("ar_pre_ready", a_ready, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_data",  a_data,  32'h0);
    chk("ar_valid", a_valid, 32'h0);
    chk("ar_ready", a_ready, 32'h1);
    chk("ar_state", a_state, 32'h0);
    step();
    reset = 1'b1;
    src_busy[5] = 1'b0;
    step();
    chk("ar_no_pulse", a_valid, 32'h0);
    req(4);
    step();
    chk("ar_new_data",  a_data,  32'h4444_4444);
    chk("ar_new_valid", a_valid, 32'h1);
    in_valid = 1'b0;
    step();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
